// File: rtl/countdown99_timer.sv
// Loadable, pausable down-counter from at most MAX to 0 with a built-in prescaler.
// Q shares the 8-bit binary format of the board's 0->99 up-counter display path.
module countdown99_timer #(
   parameter int unsigned MAX      = 99,
   parameter int unsigned PRESCALE = 100
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_load,
   input  logic [7:0] i_load_val,
   input  logic       i_start,
   input  logic       i_pause,
   output logic [7:0] o_q,
   output logic       o_running,
   output logic       o_expired,
   output logic       o_done
);

   // state      | meaning
   // ST_IDLE    | loaded or reset, waiting for start with Q != 0
   // ST_RUN     | prescaler counting, Q decrements on terminal count
   // ST_PAUSED  | Q and prescaler frozen, start resumes mid-interval
   // ST_EXPIRED | Q reached 0, start restarts from MAX
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RUN     = 2'd1,
      ST_PAUSED  = 2'd2,
      ST_EXPIRED = 2'd3
   } state_t;

   localparam int unsigned PC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PC_W-1:0] PC_TC = PC_W'(PRESCALE - 1);
   localparam logic [7:0] MAX_Q = 8'(MAX);

   state_t          r_state;
   logic [7:0]      r_q;
   logic [PC_W-1:0] r_pc;
   logic            r_running;
   logic            r_expired;
   logic            r_done;

   state_t          w_state_nxt;
   logic [7:0]      w_q_nxt;
   logic [PC_W-1:0] w_pc_nxt;
   logic            w_done_nxt;
   logic            w_tick;
   logic            w_advance;

   assign w_tick = (r_pc == PC_TC);

   always_comb begin
      w_state_nxt = r_state;
      w_q_nxt     = r_q;
      w_pc_nxt    = r_pc;
      w_done_nxt  = 1'b0;
      w_advance   = 1'b0;

      if (i_load) begin
         w_q_nxt     = (i_load_val > MAX_Q) ? MAX_Q : i_load_val;
         w_pc_nxt    = '0;
         w_state_nxt = ST_IDLE;
      end else begin
         unique case (r_state)
            ST_IDLE: begin
               if (i_start && (r_q != 8'd0)) begin
                  w_state_nxt = ST_RUN;
                  w_pc_nxt    = '0;
               end
            end
            ST_RUN: begin
               if (i_pause) begin
                  w_state_nxt = ST_PAUSED;
               end else begin
                  w_advance = 1'b1;
               end
            end
            ST_PAUSED: begin
               // the resume edge already counts toward the held partial interval
               if (i_start) begin
                  w_state_nxt = ST_RUN;
                  w_advance   = 1'b1;
               end
            end
            ST_EXPIRED: begin
               if (i_start) begin
                  w_state_nxt = ST_RUN;
                  w_q_nxt     = MAX_Q;
                  w_pc_nxt    = '0;
               end
            end
            default: w_state_nxt = ST_IDLE;
         endcase

         if (w_advance) begin
            if (w_tick) begin
               w_pc_nxt = '0;
               if (r_q != 8'd0) begin
                  w_q_nxt = r_q - 8'd1;
               end
               if (r_q <= 8'd1) begin
                  w_state_nxt = ST_EXPIRED;
                  w_done_nxt  = 1'b1;
               end
            end else begin
               w_pc_nxt = r_pc + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state   <= ST_IDLE;
         r_q       <= 8'd0;
         r_pc      <= '0;
         r_running <= 1'b0;
         r_expired <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_q       <= w_q_nxt;
         r_pc      <= w_pc_nxt;
         r_running <= (w_state_nxt == ST_RUN);
         r_expired <= (w_state_nxt == ST_EXPIRED);
         r_done    <= w_done_nxt;
      end
   end

   assign o_q       = r_q;
   assign o_running = r_running;
   assign o_expired = r_expired;
   assign o_done    = r_done;

endmodule

// File: tb/tb_countdown99_timer.sv
// Scoreboard bench for countdown99_timer: three instances (PRESCALE 1, 4, default 100)
// share clock and reset; expected outputs are queued per step and compared after the edge.
module tb_countdown99_timer;

   logic       clk;
   logic       rst;
   logic       ld    [3];
   logic [7:0] lv    [3];
   logic       st    [3];
   logic       ps    [3];
   logic [7:0] q_o   [3];
   logic       run_o [3];
   logic       exp_o [3];
   logic       done_o[3];

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      int          idx;
      string       tag;
      logic [10:0] val;
   } sb_t;

   sb_t sb[$];

   countdown99_timer #(.MAX(99), .PRESCALE(1)) u_p1 (
      .i_clk(clk), .i_rst(rst), .i_load(ld[0]), .i_load_val(lv[0]),
      .i_start(st[0]), .i_pause(ps[0]), .o_q(q_o[0]), .o_running(run_o[0]),
      .o_expired(exp_o[0]), .o_done(done_o[0]));

   countdown99_timer #(.MAX(99), .PRESCALE(4)) u_p4 (
      .i_clk(clk), .i_rst(rst), .i_load(ld[1]), .i_load_val(lv[1]),
      .i_start(st[1]), .i_pause(ps[1]), .o_q(q_o[1]), .o_running(run_o[1]),
      .o_expired(exp_o[1]), .o_done(done_o[1]));

   countdown99_timer u_def (
      .i_clk(clk), .i_rst(rst), .i_load(ld[2]), .i_load_val(lv[2]),
      .i_start(st[2]), .i_pause(ps[2]), .o_q(q_o[2]), .o_running(run_o[2]),
      .o_expired(exp_o[2]), .o_done(done_o[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [10:0] obs, input logic [10:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got q=%0d run/exp/done=%b expected q=%0d run/exp/done=%b",
                  tag, obs[10:3], obs[2:0], exp[10:3], exp[2:0]);
      end
   endtask

   task automatic drive(input int d, input bit l, input logic [7:0] v, input bit s, input bit p);
      ld[d] = l;
      lv[d] = v;
      st[d] = s;
      ps[d] = p;
   endtask

   task automatic push(input int d, input string tag, input logic [7:0] q,
                       input bit r, input bit e, input bit dn);
      sb_t item;
      item.idx = d;
      item.tag = tag;
      item.val = {q, r, e, dn};
      sb.push_back(item);
   endtask

   task automatic sample();
      sb_t item;
      while (sb.size() > 0) begin
         item = sb.pop_front();
         check(item.tag, {q_o[item.idx], run_o[item.idx], exp_o[item.idx], done_o[item.idx]},
               item.val);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      sample();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      for (int i = 0; i < 3; i++) drive(i, 0, 8'd0, 0, 0);
      #2;
      for (int i = 0; i < 3; i++) push(i, "reset", 8'd0, 0, 0, 0);
      sample();
      rst = 1'b0;

      // basic countdown, PRESCALE=1
      drive(0, 1, 8'd5, 0, 0); push(0, "p1_load5", 8'd5, 0, 0, 0); tick();
      drive(0, 0, 8'd0, 1, 0); push(0, "p1_start", 8'd5, 1, 0, 0); tick();
      drive(0, 0, 8'd0, 0, 0);
      for (int n = 4; n >= 1; n--) begin
         push(0, $sformatf("p1_cnt%0d", n), n[7:0], 1, 0, 0); tick();
      end
      push(0, "p1_expire", 8'd0, 0, 1, 1); tick();
      drive(0, 0, 8'd0, 0, 1); push(0, "p1_done_once", 8'd0, 0, 1, 0); tick();
      drive(0, 0, 8'd0, 0, 0); push(0, "p1_exp_hold", 8'd0, 0, 1, 0); tick();

      // clamp and restart
      drive(0, 1, 8'd255, 0, 0); push(0, "clamp255", 8'd99, 0, 0, 0); tick();
      drive(0, 1, 8'd150, 0, 0); push(0, "clamp150", 8'd99, 0, 0, 0); tick();
      drive(0, 0, 8'd0, 1, 0); push(0, "clamp_start", 8'd99, 1, 0, 0); tick();
      drive(0, 0, 8'd0, 0, 0);
      for (int n = 98; n >= 1; n--) begin
         push(0, $sformatf("clamp_cnt%0d", n), n[7:0], 1, 0, 0); tick();
      end
      push(0, "clamp_expire", 8'd0, 0, 1, 1); tick();
      drive(0, 0, 8'd0, 1, 0); push(0, "restart", 8'd99, 1, 0, 0); tick();
      drive(0, 0, 8'd0, 0, 0); push(0, "restart_dec", 8'd98, 1, 0, 0); tick();

      // pause and resume, PRESCALE=4
      drive(1, 1, 8'd3, 0, 0); push(1, "p4_load3", 8'd3, 0, 0, 0); tick();
      drive(1, 0, 8'd0, 1, 0); push(1, "p4_start", 8'd3, 1, 0, 0); tick();
      drive(1, 0, 8'd0, 0, 0); push(1, "p4_k1", 8'd3, 1, 0, 0); tick();
      drive(1, 0, 8'd0, 0, 1); push(1, "p4_pause", 8'd3, 0, 0, 0); tick();
      for (int i = 0; i < 10; i++) begin
         push(1, $sformatf("p4_held%0d", i), 8'd3, 0, 0, 0); tick();
      end
      drive(1, 0, 8'd0, 1, 0); push(1, "p4_resume", 8'd3, 1, 0, 0); tick();
      drive(1, 0, 8'd0, 0, 0); push(1, "p4_resume1", 8'd3, 1, 0, 0); tick();
      push(1, "p4_resume2_dec", 8'd2, 1, 0, 0); tick();

      // simultaneous inputs
      drive(1, 0, 8'd0, 1, 1); push(1, "p4_sp_in_run", 8'd2, 0, 0, 0); tick();
      push(1, "p4_sp_in_paused", 8'd2, 1, 0, 0); tick();
      drive(1, 0, 8'd0, 0, 0); push(1, "p4_pc2", 8'd2, 1, 0, 0); tick();
      push(1, "p4_pc3", 8'd2, 1, 0, 0); tick();
      push(1, "p4_dec1", 8'd1, 1, 0, 0); tick();
      drive(1, 1, 8'd7, 1, 0); push(1, "p4_load_start", 8'd7, 0, 0, 0); tick();
      drive(1, 0, 8'd0, 0, 1); push(1, "p4_idle_pause", 8'd7, 0, 0, 0); tick();
      drive(1, 1, 8'd0, 0, 0); push(1, "p4_load0", 8'd0, 0, 0, 0); tick();
      drive(1, 0, 8'd0, 1, 0); push(1, "p4_start_q0", 8'd0, 0, 0, 0); tick();
      push(1, "p4_start_q0_hold", 8'd0, 0, 0, 0); tick();
      drive(1, 0, 8'd0, 0, 0);

      // default parameters
      drive(2, 1, 8'd2, 0, 0); push(2, "def_load2", 8'd2, 0, 0, 0); tick();
      drive(2, 0, 8'd0, 1, 0); push(2, "def_start", 8'd2, 1, 0, 0); tick();
      drive(2, 0, 8'd0, 0, 0);
      for (int c = 1; c <= 201; c++) begin
         if (c == 99)  push(2, "def_c99",  8'd2, 1, 0, 0);
         if (c == 100) push(2, "def_c100", 8'd1, 1, 0, 0);
         if (c == 199) push(2, "def_c199", 8'd1, 1, 0, 0);
         if (c == 200) push(2, "def_c200", 8'd0, 0, 1, 1);
         if (c == 201) push(2, "def_c201", 8'd0, 0, 1, 0);
         tick();
      end

      // async reset mid-run
      drive(2, 1, 8'd40, 0, 0); push(2, "rst_load40", 8'd40, 0, 0, 0); tick();
      drive(2, 0, 8'd0, 1, 0); push(2, "rst_start", 8'd40, 1, 0, 0); tick();
      drive(2, 0, 8'd0, 0, 0); push(2, "rst_running", 8'd40, 1, 0, 0); tick();
      #3;
      rst = 1'b1;
      #1;
      push(2, "rst_async", 8'd0, 0, 0, 0); sample();
      #2;
      rst = 1'b0;
      drive(2, 0, 8'd0, 1, 0); push(2, "rst_start_ignored", 8'd0, 0, 0, 0); tick();
      drive(2, 0, 8'd0, 0, 0); push(2, "rst_idle_hold", 8'd0, 0, 0, 0); tick();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/countdown99_timer.md
# countdown99_timer

Loadable, pausable down-counter that runs a value from at most 99 down to 0 and flags expiry. It is the decrementing counterpart to the board's 0→99 up-counter. It shares the same 8-bit binary `Q` value format, so either counter can drive the same display path (`right`, seven-segment digits). A built-in prescaler derives the decrement rate from the 100 Hz board clock.

## Interface
- `MAX`, default 99: upper bound of the count. Loads are clamped to it, and it is the restart value. Legal range 1..255.
- `PRESCALE`, default 100: `CLK` cycles per decrement. Legal range ≥1; 100 gives a 1 Hz decrement on `hz100`.
- `CLK` input, 1 bit: single clock (`hz100` at top level). All logic is on the rising edge.
- `RST` input, 1 bit: asynchronous, active-high reset.
- `load` input, 1 bit: load `load_val` this cycle.
- `load_val` input, 8 bits: value to load, unsigned binary.
- `start` input, 1 bit: start, resume or restart, level-sampled per cycle.
- `pause` input, 1 bit: pause request, level-sampled per cycle.
- `Q` output, 8 bits: current count, unsigned binary.
- `running` output, 1 bit: high while in RUN.
- `expired` output, 1 bit: high while in EXPIRED.
- `done` output, 1 bit: one-cycle pulse on expiry.

## Operation
- **States:** IDLE, RUN, PAUSED, EXPIRED. All outputs are registered.
- **Reset (async, immediate):**
  - State goes to IDLE.
  - `Q`=0, `running`=0, `expired`=0, `done`=0.
  - Prescaler count `pc`=0.
- **Priority per cycle:** `load` > `start`/`pause` > tick.
- **`load` in any state:**
  - `Q` ← min(`load_val`, `MAX`).
  - State goes to IDLE and `pc` ← 0.
  - `start`/`pause` in the same cycle are ignored.
- **IDLE:**
  - `start` with `Q`≠0 goes to RUN, with `pc` ← 0.
  - `start` with `Q`=0 is ignored.
  - `pause` is ignored.
- **RUN:**
  - `pause` goes to PAUSED, holding `Q` and `pc`. Pause wins over `start` in the same cycle.
  - Otherwise `pc` increments. When `pc`=`PRESCALE`−1, `pc` ← 0 and `Q` ← `Q`−1.
  - If that decrement takes `Q` from 1 to 0, go to EXPIRED on the same edge.
- **PAUSED:**
  - `start` goes to RUN and continues from the held `pc`; the partial prescale interval is not restarted.
  - `start` wins over `pause` in the same cycle.
  - `pause` alone holds the state.
- **EXPIRED:**
  - `Q` holds at 0 and the state holds.
  - `start` restarts: `Q` ← `MAX`, `pc` ← 0, go to RUN.
  - `pause` is ignored.
- **Wrap/boundary:**
  - `Q` never underflows.
  - `Q` never exceeds `MAX`, including `load_val`=255.
  - With `PRESCALE`=1 the prescaler width is 1 bit and every RUN cycle is a tick.

## Timing
- Inputs are sampled on the rising edge of `CLK`. Effects are visible in the following cycle.
- **Start latency:** `start` sampled at edge k makes `running`=1 from edge k.
- **First decrement:** at edge k+`PRESCALE`.
- **Total run time:** `Q`=N reaches 0 at edge k+N·`PRESCALE`, with no pauses.
- **`done`:** high for exactly one cycle, the first cycle with `Q`=0 and `expired`=1.
  - It is not reasserted while the counter remains in EXPIRED.
  - It is never asserted by `load` 0 or by reset.
- **`running` and `expired`:** mutually exclusive, and both track the state with zero extra latency.
- **Pause:** `Q` does not change on the pause edge, even if `pc` would have reached terminal there.
- **Reset mid-run:** outputs clear without waiting for an edge. The first edge after `RST` deasserts starts from IDLE.

## Test plan
- **Basic countdown (`PRESCALE`=1):** reset, `load` 5, then `start` → `Q` = 5,4,3,2,1,0 on consecutive edges. `done`=1 for exactly one cycle with `Q`=0, `expired` stays 1, `running`=0.
- **Clamp and restart:** `load` 150 → `Q`=99. Run to expiry, then `start` → `Q`=99, `running`=1. Decrement resumes `PRESCALE` cycles later.
- **Pause and resume (`PRESCALE`=4):** `load` 3, `start`, `pause` 2 cycles after start, hold 10 cycles → `Q` stays 3. `start` → `Q`=2 exactly 2 cycles after resume.
- **Simultaneous inputs:**
  - `load`+`start` → IDLE with loaded `Q`.
  - `start`+`pause` in RUN → PAUSED.
  - `start`+`pause` in PAUSED → RUN.
  - `start` in IDLE with `Q`=0 → stays IDLE, `done`=0.
- **Async reset mid-run:** assert `RST` between edges while `Q`=40 in RUN → `Q`=0, `running`=0, `done`=0 before the next edge. Release, then `start` is ignored because `Q`=0.
- **Default parameters:** `PRESCALE`=100, `load` 2, `start` → `Q`=1 at cycle 100 and `Q`=0 at cycle 200, `done` pulses at cycle 200.
